// File: rtl/cic_decimator.sv
// N-stage CIC decimator: pipelined integrators at the input rate, pipelined combs at the
// decimated rate. Optional output rounding/saturation to +/-16384 under `CIC_OUT_SCALE_EN.
module cic_decimator #(
  parameter int R_LOG2 = 6,
  parameter int N      = 5,
  parameter int W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [1:0]   Din,
  output logic signed [W-1:0] Dout,
  output logic                Dout_valid
);

  localparam logic [R_LOG2-1:0] CNT_MAX = '1;

  logic signed [W-1:0] r_integ   [1:N];
  logic signed [W-1:0] r_comb    [1:N];
  logic signed [W-1:0] r_dly     [1:N];
  logic signed [W-1:0] w_comb_in [1:N];
  logic signed [W-1:0] r_sample;
  logic [R_LOG2-1:0]   r_cnt;
  logic [N+1:1]        r_stb;
  logic                w_dec_stb;
  logic signed [W-1:0] w_din_ext;
  logic signed [W-1:0] w_out;

  assign w_din_ext = {{(W-2){Din[1]}}, Din};
  assign w_dec_stb = (r_cnt == CNT_MAX);

  // Integrators wrap modulo 2^W; the combs recover the exact difference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= N; k++) r_integ[k] <= '0;
    end else begin
      r_integ[1] <= r_integ[1] + w_din_ext;
      for (int k = 2; k <= N; k++) r_integ[k] <= r_integ[k] + r_integ[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_stb    <= '0;
      r_sample <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      r_stb <= {r_stb[N:1], w_dec_stb};
      if (w_dec_stb) r_sample <= r_integ[N];
    end
  end

  always_comb begin
    w_comb_in[1] = r_sample;
    for (int k = 2; k <= N; k++) w_comb_in[k] = r_comb[k-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= N; k++) begin
        r_comb[k] <= '0;
        r_dly[k]  <= '0;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (r_stb[k]) begin
          r_comb[k] <= w_comb_in[k] - r_dly[k];
          r_dly[k]  <= w_comb_in[k];
        end
      end
    end
  end

`ifdef CIC_OUT_SCALE_EN
  localparam int S = N*R_LOG2 - 14;
  localparam logic signed [W:0] RND   = (W+1)'(1) << (S-1);
  localparam logic signed [W:0] SAT_P = (W+1)'(16384);
  localparam logic signed [W:0] SAT_N = -(W+1)'(16384);

  logic signed [W:0] w_rnd_sum;
  logic signed [W:0] w_shift;

  // One extra bit keeps the rounding add from overflowing near full scale.
  assign w_rnd_sum = {r_comb[N][W-1], r_comb[N]} + RND;
  assign w_shift   = w_rnd_sum >>> S;

  always_comb begin
    w_out = w_shift[W-1:0];
    if (w_shift > SAT_P)      w_out = SAT_P[W-1:0];
    else if (w_shift < SAT_N) w_out = SAT_N[W-1:0];
  end
`else
  assign w_out = r_comb[N];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Dout       <= '0;
      Dout_valid <= 1'b0;
    end else begin
      Dout_valid <= r_stb[N+1];
      if (r_stb[N+1]) Dout <= w_out;
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator: stimulus pushes expected strobe edges/values,
// a negedge monitor pops and compares on every Dout_valid.
module tb_cic_decimator;

  localparam int W = 32;

`ifdef CIC_OUT_SCALE_EN
  localparam logic signed [31:0] POS_FS = 32'sd16384;
  localparam logic signed [31:0] NEG_FS = -32'sd16384;
`else
  localparam logic signed [31:0] POS_FS = 32'sd1073741824;
  localparam logic signed [31:0] NEG_FS = -32'sd1073741824;
`endif

  typedef struct packed {
    logic        chk;
    logic [31:0] edge_no;
    logic [31:0] val;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [1:0]          Din = 2'b00;
  logic signed [W-1:0] Dout;
  logic                Dout_valid;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   edge_cnt;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  cic_decimator #(.R_LOG2(6), .N(5), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .Din       (Din),
    .Dout      (Dout),
    .Dout_valid(Dout_valid)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && Dout_valid) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strobe: got strobe at edge %0d, expected none", edge_cnt);
      end else begin
        e = sb_q.pop_front();
        check("strobe_edge", edge_cnt, longint'(e.edge_no));
        if (e.chk) check("strobe_dout", $signed(Dout), $signed(e.val));
      end
    end
  end

  // Strobes land at edge 70 + 64*m; values are checked from strobe first_chk onward.
  task automatic run_phase(input string tag, input logic [1:0] d, input bit alt,
                           input int nstb, input int first_chk, input logic signed [31:0] v);
    exp_t e;
    int   hold_from;
    hold_from = 70 + 64*(first_chk-1);
    for (int m = 0; m < nstb; m++) begin
      e.chk     = (m + 1 >= first_chk);
      e.edge_no = 32'(70 + 64*m);
      e.val     = v;
      sb_q.push_back(e);
    end
    Din = d;
    @(negedge clk);
    rst = 1'b0;
    repeat (70 + 64*(nstb-1) + 3) begin
      @(negedge clk);
      if (alt) Din = {~Din[1], 1'b1};
      if (edge_cnt >= hold_from) check({tag, "_hold"}, $signed(Dout), v);
    end
    check({tag, "_strobes_left"}, sb_q.size(), 0);
    rst = 1'b1;
    sb_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      Din = (Din == 2'b01) ? 2'b11 : 2'b01;
      check("reset_dout", $signed(Dout), 0);
      check("reset_valid", Dout_valid, 0);
    end

    // 24 strobes: integrators wrap modulo 2^32 within the first few hundred clocks
    run_phase("dc_pos",  2'b01, 1'b0, 24, 6, POS_FS);
    run_phase("dc_neg",  2'b11, 1'b0,  8, 6, NEG_FS);
    run_phase("alt",     2'b01, 1'b1,  8, 6, 32'sd0);
    run_phase("zero",    2'b00, 1'b0,  8, 1, 32'sd0);

    sb_q.push_back('{chk: 1'b0, edge_no: 32'd70, val: 32'd0});
    Din = 2'b01;
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_dout", $signed(Dout), 0);
    check("midrst_valid", Dout_valid, 0);
    check("midrst_strobes_left", sb_q.size(), 0);
    sb_q.delete();
    repeat (5) @(negedge clk);
    run_phase("after_rst", 2'b01, 1'b0, 8, 6, POS_FS);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
